exe_stage: RTL and testbench

- Execute (EX) stage of the 5-stage MIPS32-style pipeline.
- Takes the ID/EX operands (A, B, Imm, NPC, IR), decodes the opcode and computes the ALU result and the branch condition.
- Registers the results into the EX/MEM pipeline register. Outputs feed the MEM stage.

---
 rtl/exe_stage.sv | 112 +++++++++++
 tb/tb_exe_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS32-style pipeline.
// Decodes the opcode, runs the ALU and branch test, registers EX/MEM.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] NPC_id,
  input  logic [WIDTH-1:0] IR_id,
  output logic [WIDTH-1:0] NPC_ex,
  output logic [WIDTH-1:0] IR_ex,
  output logic [WIDTH-1:0] ALU_res,
  output logic             cond,
  output logic [WIDTH-1:0] B_ex
);

  localparam logic [5:0] OP_LW    = 6'h30;
  localparam logic [5:0] OP_SW    = 6'h31;
  localparam logic [5:0] OP_BNEQZ = 6'h34;
  localparam logic [5:0] OP_BEQZ  = 6'h35;

  logic [5:0] opcode;
  logic [1:0] cls;
  logic [3:0] func;

  assign opcode = IR_id[31:26];
  assign cls    = IR_id[31:30];
  assign func   = IR_id[29:26];

  logic is_rr;
  logic is_ri;
  logic is_mem;
  logic is_bnez;
  logic is_beqz;
  logic is_br;
  logic is_arith;

  assign is_rr    = (cls == 2'b00);
  assign is_ri    = (cls == 2'b01);
  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_bnez  = (opcode == OP_BNEQZ);
  assign is_beqz  = (opcode == OP_BEQZ);
  assign is_br    = is_bnez || is_beqz;
  assign is_arith = (is_rr || is_ri) && (func <= 4'd5);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign op_a = is_br ? NPC_id : A;
  assign op_b = is_rr ? B : Imm;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prod;
  logic             lt;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign prod = op_a * op_b;
  assign lt   = $signed(op_a) < $signed(op_b);

  logic [WIDTH-1:0] arith;

  always_comb begin
    arith = '0;
    case (func)
      4'd0:    arith = sum;
      4'd1:    arith = diff;
      4'd2:    arith = op_a & op_b;
      4'd3:    arith = op_a | op_b;
      4'd4:    arith = {{(WIDTH-1){1'b0}}, lt};
      4'd5:    arith = prod;
      default: arith = '0;
    endcase
  end

  logic [WIDTH-1:0] alu_next;
  logic             cond_next;

  // Undefined opcodes fall to the default and produce zero.
  always_comb begin
    alu_next = '0;
    unique case (1'b1)
      is_arith: alu_next = arith;
      is_mem:   alu_next = sum;
      is_br:    alu_next = sum;
      default:  alu_next = '0;
    endcase
  end

  assign cond_next = (is_bnez && (|A)) || (is_beqz && !(|A));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      NPC_ex  <= '0;
      IR_ex   <= '0;
      ALU_res <= '0;
      cond    <= 1'b0;
      B_ex    <= '0;
    end else begin
      NPC_ex  <= NPC_id;
      IR_ex   <= IR_id;
      ALU_res <= alu_next;
      cond    <= cond_next;
      B_ex    <= B;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
// Hand-computed vectors, one capture edge per step.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Imm;
  logic [31:0] NPC_id;
  logic [31:0] IR_id;
  logic [31:0] NPC_ex;
  logic [31:0] IR_ex;
  logic [31:0] ALU_res;
  logic        cond;
  logic [31:0] B_ex;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .Imm     (Imm),
    .NPC_id  (NPC_id),
    .IR_id   (IR_id),
    .NPC_ex  (NPC_ex),
    .IR_ex   (IR_ex),
    .ALU_res (ALU_res),
    .cond    (cond),
    .B_ex    (B_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic [31:0] ir,
                      input logic [31:0] exp_alu,
                      input logic        exp_cond);
    logic [31:0] npc_s;
    logic [31:0] b_s;
    IR_id = ir;
    npc_s = NPC_id;
    b_s   = B;
    @(posedge clk);
    #1;
    chk({tag, ".alu"},  ALU_res, exp_alu);
    chk({tag, ".cond"}, {31'd0, cond}, {31'd0, exp_cond});
    chk({tag, ".ir"},   IR_ex, ir);
    chk({tag, ".npc"},  NPC_ex, npc_s);
    chk({tag, ".b"},    B_ex, b_s);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu"},  ALU_res, 32'd0);
    chk({tag, ".cond"}, {31'd0, cond}, 32'd0);
    chk({tag, ".ir"},   IR_ex, 32'd0);
    chk({tag, ".npc"},  NPC_ex, 32'd0);
    chk({tag, ".b"},    B_ex, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    A      = 32'd5;
    B      = 32'd3;
    Imm    = 32'd2;
    NPC_id = 32'h100;
    IR_id  = 32'h0000_0000;

    // Reset held two edges with live inputs
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("rst");

    rst_n = 1'b1;
    step("rel_add", 32'h0000_0000, 32'd8, 1'b0);

    step("add", 32'h0000_0000, 32'd8,  1'b0);
    step("sub", 32'h0400_0000, 32'd2,  1'b0);
    step("and", 32'h0800_0000, 32'd1,  1'b0);
    step("or",  32'h0C00_0000, 32'd7,  1'b0);
    step("slt", 32'h1000_0000, 32'd0,  1'b0);
    step("mul", 32'h1400_0000, 32'hF,  1'b0);

    step("addi", 32'h4000_0000, 32'd7,  1'b0);
    step("subi", 32'h4400_0000, 32'd3,  1'b0);
    step("andi", 32'h4800_0000, 32'd0,  1'b0);
    step("ori",  32'h4C00_0000, 32'd7,  1'b0);
    step("slti", 32'h5000_0000, 32'd0,  1'b0);
    step("muli", 32'h5400_0000, 32'hA,  1'b0);

    step("lw", 32'hC000_0000, 32'd7, 1'b0);
    step("sw", 32'hC400_0000, 32'd7, 1'b0);

    step("bnez_a5", 32'hD000_0000, 32'h102, 1'b1);
    step("beqz_a5", 32'hD400_0000, 32'h102, 1'b0);
    A = 32'd0;
    step("bnez_a0", 32'hD000_0000, 32'h102, 1'b0);
    step("beqz_a0", 32'hD400_0000, 32'h102, 1'b1);

    A = 32'd0;
    B = 32'd1;
    step("sub_wrap", 32'h0400_0000, 32'hFFFF_FFFF, 1'b0);

    A = 32'h7FFF_FFFF;
    step("add_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

    A = 32'hFFFF_FFFF;
    step("slt_neg", 32'h1000_0000, 32'd1, 1'b0);

    A = 32'h0001_0001;
    B = 32'h0001_0001;
    step("mul_lo", 32'h1400_0000, 32'h0002_0001, 1'b0);

    A      = 32'd5;
    B      = 32'h1234_5678;
    NPC_id = 32'h200;
    step("undef_c2", 32'h8000_0000, 32'd0, 1'b0);
    step("undef_3f", 32'hFC00_0000, 32'd0, 1'b0);
    step("undef_f6", 32'h1800_0000, 32'd0, 1'b0);
    A = 32'd0;
    step("undef_br", 32'hD800_0000, 32'd0, 1'b0);

    // Mid-stream reset overrides a branch that would set cond
    IR_id = 32'hD400_0000;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst_mid");
    rst_n = 1'b1;
    step("resume", 32'hD400_0000, 32'h202, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
